// File: rtl/pwr_seq_pkg.sv
// Shared types for the power-up sequencer: state encoding, error codes, retry limit.
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        INIT,
        CAL,
        RUN,
        SHUTDN,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_EXT  = 2'b01,
        ERR_TMO  = 2'b10
    } err_t;

    localparam logic [1:0] MAX_RETRY = 2'd3;

endpackage

// File: rtl/seq_timer.sv
// State-duration counter shared by all timed states; saturates at the terminal
// count so it can never wrap.
module seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    assign o_done = (r_cnt == i_term);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwr_up_seq.sv
// Power-up / enable sequencer: sensors -> IMU init -> balance -> motors, with
// ordered shutdown and fault latching. Optional macro PWR_SEQ_AUTO_RETRY_EN.
module pwr_up_seq
    import pwr_seq_pkg::*;
#(
    parameter int             CNT_W      = 16,
    parameter logic [CNT_W-1:0] SETTLE_CYC = 16'd1000,
    parameter logic [CNT_W-1:0] INIT_TMO   = 16'd50000,
    parameter logic [CNT_W-1:0] CAL_CYC    = 16'd4000,
    parameter logic [CNT_W-1:0] STOP_CYC   = 16'd500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_up,
    input  logic       fault,
    input  logic       init_done,
    output logic       init_req,
    output logic       sens_en,
    output logic       bal_en,
    output logic       mtr_en,
    output logic       ready,
    output logic       fault_latched,
    output logic [1:0] err_code
);

    state_t           r_state;
    state_t           w_nxt;
    err_t             r_err;
    logic             r_init_req, r_sens_en, r_bal_en, r_mtr_en, r_ready, r_fault_lat;
    logic             w_tmo, w_clr, w_en, w_done;
    logic [CNT_W-1:0] w_term;
`ifdef PWR_SEQ_AUTO_RETRY_EN
    logic [1:0]       r_retry;
    logic             w_retry_go;
`endif

    // Terminal is N-1 because the counter reads 0 on the first cycle of a state.
    always_comb begin
        w_en   = 1'b0;
        w_term = '0;
        case (r_state)
            SETTLE:  begin w_en = 1'b1; w_term = SETTLE_CYC - CNT_W'(1); end
            INIT:    begin w_en = 1'b1; w_term = INIT_TMO   - CNT_W'(1); end
            CAL:     begin w_en = 1'b1; w_term = CAL_CYC    - CNT_W'(1); end
            SHUTDN:  begin w_en = 1'b1; w_term = STOP_CYC   - CNT_W'(1); end
`ifdef PWR_SEQ_AUTO_RETRY_EN
            FAULT:   begin w_en = 1'b1; w_term = SETTLE_CYC - CNT_W'(1); end
`endif
            default: begin w_en = 1'b0; w_term = '0; end
        endcase
    end

    // In FAULT the counter measures consecutive fault-low cycles, so fault clears it.
    assign w_clr = (w_nxt != r_state) || ((r_state == FAULT) && fault);

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_term (w_term),
        .o_done (w_done)
    );

    always_comb begin
        w_nxt = r_state;
        w_tmo = 1'b0;
`ifdef PWR_SEQ_AUTO_RETRY_EN
        w_retry_go = 1'b0;
`endif
        case (r_state)
            IDLE: if (pwr_up && !fault) w_nxt = SETTLE;
            SETTLE: begin
                if (fault)       w_nxt = FAULT;
                else if (!pwr_up) w_nxt = SHUTDN;
                else if (w_done)  w_nxt = INIT;
            end
            INIT: begin
                if (fault)          w_nxt = FAULT;
                else if (!pwr_up)   w_nxt = SHUTDN;
                else if (init_done) w_nxt = CAL;
                else if (w_done) begin
                    w_nxt = FAULT;
                    w_tmo = 1'b1;
                end
            end
            CAL: begin
                if (fault)       w_nxt = FAULT;
                else if (!pwr_up) w_nxt = SHUTDN;
                else if (w_done)  w_nxt = RUN;
            end
            RUN: begin
                if (fault)       w_nxt = FAULT;
                else if (!pwr_up) w_nxt = SHUTDN;
            end
            SHUTDN: begin
                if (fault)       w_nxt = FAULT;
                else if (w_done) w_nxt = IDLE;
            end
            FAULT: begin
                if (!pwr_up && !fault) w_nxt = IDLE;
`ifdef PWR_SEQ_AUTO_RETRY_EN
                else if ((r_err == ERR_TMO) && (r_retry < MAX_RETRY) && !fault && w_done) begin
                    w_nxt      = SETTLE;
                    w_retry_go = 1'b1;
                end
`endif
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_init_req  <= 1'b0;
            r_sens_en   <= 1'b0;
            r_bal_en    <= 1'b0;
            r_mtr_en    <= 1'b0;
            r_ready     <= 1'b0;
            r_fault_lat <= 1'b0;
            r_err       <= ERR_NONE;
        end else begin
            r_state     <= w_nxt;
            r_init_req  <= (w_nxt == INIT) && (r_state != INIT);
            r_sens_en   <= (w_nxt == SHUTDN) ? r_sens_en : (w_nxt inside {SETTLE, INIT, CAL, RUN});
            r_bal_en    <= (w_nxt == SHUTDN) ? r_bal_en  : (w_nxt inside {CAL, RUN});
            r_mtr_en    <= (w_nxt == RUN);
            r_ready     <= (w_nxt == RUN);
            r_fault_lat <= (w_nxt == FAULT);
            if (w_nxt != FAULT)
                r_err <= ERR_NONE;
            else if (r_state != FAULT)
                r_err <= w_tmo ? ERR_TMO : ERR_EXT;
        end
    end

`ifdef PWR_SEQ_AUTO_RETRY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_retry <= 2'd0;
        else if (w_nxt == RUN)
            r_retry <= 2'd0;
        else if (w_retry_go)
            r_retry <= r_retry + 2'd1;
    end
`endif

    assign init_req      = r_init_req;
    assign sens_en       = r_sens_en;
    assign bal_en        = r_bal_en;
    assign mtr_en        = r_mtr_en;
    assign ready         = r_ready;
    assign fault_latched = r_fault_lat;
    assign err_code      = r_err;

endmodule

// File: tb/tb_pwr_up_seq.sv
// Bench for pwr_up_seq: directed vector table followed by randomized stimulus
// checked against a phase/age reference model.
module tb_pwr_up_seq;

    localparam int TS = 4, TI = 20, TC = 8, TP = 3;

    logic       clk = 1'b0;
    logic       rst_n, pwr_up, fault, init_done;
    logic       init_req, sens_en, bal_en, mtr_en, ready, fault_latched;
    logic [1:0] err_code;

    pwr_up_seq #(
        .CNT_W(16), .SETTLE_CYC(16'd4), .INIT_TMO(16'd20), .CAL_CYC(16'd8), .STOP_CYC(16'd3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .fault(fault), .init_done(init_done),
        .init_req(init_req), .sens_en(sens_en), .bal_en(bal_en), .mtr_en(mtr_en),
        .ready(ready), .fault_latched(fault_latched), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // {init_req, sens_en, bal_en, mtr_en, ready, fault_latched, err_code}
    localparam bit [7:0] O_OFF  = 8'b0000_0000;
    localparam bit [7:0] O_SET  = 8'b0100_0000;
    localparam bit [7:0] O_REQ  = 8'b1100_0000;
    localparam bit [7:0] O_CAL  = 8'b0110_0000;
    localparam bit [7:0] O_RUN  = 8'b0111_1000;
    localparam bit [7:0] O_FEXT = 8'b0000_0101;
    localparam bit [7:0] O_FTMO = 8'b0000_0110;

    typedef struct {
        bit       rn, pu, fl, id;
        bit [7:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input bit rn, pu, fl, id, input bit [7:0] exp);
        vec_t v;
        v.rn = rn; v.pu = pu; v.fl = fl; v.id = id; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic add_n(input int n, input bit pu, fl, id, input bit [7:0] exp);
        for (int k = 0; k < n; k++) add(1'b1, pu, fl, id, exp);
    endtask

    // From IDLE: SETTLE_CYC cycles of SETTLE, then the INIT entry with init_req.
    task automatic to_init();
        add_n(TS, 1'b1, 1'b0, 1'b0, O_SET);
        add(1'b1, 1'b1, 1'b0, 1'b0, O_REQ);
    endtask

    task automatic to_run();
        to_init();
        add_n(4, 1'b1, 1'b0, 1'b0, O_SET);
        add(1'b1, 1'b1, 1'b0, 1'b1, O_CAL);
        add_n(TC - 1, 1'b1, 1'b0, 1'b0, O_CAL);
        add(1'b1, 1'b1, 1'b0, 1'b0, O_RUN);
    endtask

    function automatic bit [7:0] dut_out();
        return {init_req, sens_en, bal_en, mtr_en, ready, fault_latched, err_code};
    endfunction

    task automatic apply_check(input string name, input int idx, input bit rn, pu, fl, id,
                               input bit [7:0] exp);
        bit [7:0] got;
        rst_n = rn; pwr_up = pu; fault = fl; init_done = id;
        @(posedge clk);
        #1;
        got = dut_out();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: outputs got %b expected %b (req,sens,bal,mtr,rdy,flt,err)",
                     name, idx, got, exp);
        end
    endtask

    // Reference model: phase plus number of cycles already spent in it.
    localparam int M_IDLE = 0, M_SETTLE = 1, M_INIT = 2, M_CAL = 3, M_RUN = 4,
                   M_SHUT = 5, M_FAULT = 6;
    int       m_ph, m_age, m_low, m_retries;
    bit       m_req, m_hs, m_hb;
    bit [1:0] m_err;

    function automatic bit [7:0] model_out();
        bit s, b, r;
        s = (m_ph inside {M_SETTLE, M_INIT, M_CAL, M_RUN}) || (m_ph == M_SHUT && m_hs);
        b = (m_ph inside {M_CAL, M_RUN}) || (m_ph == M_SHUT && m_hb);
        r = (m_ph == M_RUN);
        return {m_req, s, b, r, r, (m_ph == M_FAULT), m_err};
    endfunction

    task automatic model_step(input bit rn, pu, fl, id);
        int       nph;
        bit [1:0] nerr;
        bit [7:0] cur;
        cur  = model_out();
        m_age++;
        nph  = m_ph;
        nerr = m_err;
        if (!rn) begin
            nph = M_IDLE; nerr = 2'b00; m_retries = 0;
        end else if (m_ph == M_IDLE) begin
            if (pu && !fl) nph = M_SETTLE;
        end else if (m_ph == M_FAULT) begin
            m_low = fl ? 0 : m_low + 1;
            if (!pu && !fl) begin
                nph = M_IDLE; nerr = 2'b00;
            end
`ifdef PWR_SEQ_AUTO_RETRY_EN
            else if (m_err == 2'b10 && m_retries < 3 && m_low >= TS) begin
                nph = M_SETTLE; nerr = 2'b00; m_retries++;
            end
`endif
        end else if (fl) begin
            nph = M_FAULT; nerr = 2'b01;
        end else if (!pu && m_ph != M_SHUT) begin
            nph = M_SHUT;
        end else begin
            case (m_ph)
                M_SETTLE: if (m_age == TS) nph = M_INIT;
                M_INIT: begin
                    if (id) nph = M_CAL;
                    else if (m_age == TI) begin nph = M_FAULT; nerr = 2'b10; end
                end
                M_CAL:  if (m_age == TC) nph = M_RUN;
                M_SHUT: if (m_age == TP) nph = M_IDLE;
                default: ;
            endcase
        end
        if (nph == M_RUN) m_retries = 0;
        m_req = (nph == M_INIT) && (m_ph != M_INIT) && rn;
        if (nph == M_SHUT && m_ph != M_SHUT) begin
            m_hs = cur[6]; m_hb = cur[5];
        end
        if (nph != m_ph || !rn) begin
            m_age = 0; m_low = 0;
        end
        m_ph  = nph;
        m_err = nerr;
    endtask

    initial begin
        bit rn, pu, fl, id;
        rst_n = 1'b0; pwr_up = 1'b0; fault = 1'b0; init_done = 1'b0;

        // Reset, nominal bring-up, shutdown with pwr_up reasserted mid-shutdown.
        add(1'b0, 1'b0, 1'b0, 1'b0, O_OFF);
        to_run();
        add(1'b1, 1'b1, 1'b0, 1'b0, O_RUN);
        add(1'b1, 1'b0, 1'b0, 1'b0, O_CAL);
        add_n(TP - 1, 1'b1, 1'b0, 1'b0, O_CAL);
        add(1'b1, 1'b0, 1'b0, 1'b0, O_OFF);
        add(1'b1, 1'b0, 1'b0, 1'b0, O_OFF);
        // Fault in IDLE only blocks the start.
        add_n(2, 1'b1, 1'b1, 1'b0, O_OFF);
        // Init timeout, then exit via pwr_up drop.
        to_init();
        add_n(TI - 1, 1'b1, 1'b0, 1'b0, O_SET);
        add(1'b1, 1'b1, 1'b0, 1'b0, O_FTMO);
        add(1'b1, 1'b1, 1'b0, 1'b0, O_FTMO);
        add(1'b1, 1'b0, 1'b0, 1'b0, O_OFF);
        add(1'b1, 1'b0, 1'b0, 1'b0, O_OFF);
        // init_done on the timeout cycle wins, then fault in CAL.
        to_init();
        add_n(TI - 1, 1'b1, 1'b0, 1'b0, O_SET);
        add(1'b1, 1'b1, 1'b0, 1'b1, O_CAL);
        add(1'b1, 1'b1, 1'b1, 1'b0, O_FEXT);
        add(1'b1, 1'b1, 1'b0, 1'b0, O_FEXT);
        add(1'b1, 1'b0, 1'b1, 1'b0, O_FEXT);
        add(1'b1, 1'b0, 1'b0, 1'b0, O_OFF);
        // init_done on first INIT cycle; fault and pwr_up drop together in RUN.
        to_init();
        add(1'b1, 1'b1, 1'b0, 1'b1, O_CAL);
        add_n(TC - 1, 1'b1, 1'b0, 1'b0, O_CAL);
        add(1'b1, 1'b1, 1'b0, 1'b0, O_RUN);
        add(1'b1, 1'b0, 1'b1, 1'b0, O_FEXT);
        add(1'b1, 1'b0, 1'b0, 1'b0, O_OFF);
        // Reset mid-RUN, then shutdown from SETTLE keeps only sens_en.
        to_run();
        add(1'b0, 1'b1, 1'b0, 1'b0, O_OFF);
        add(1'b1, 1'b1, 1'b0, 1'b0, O_SET);
        add_n(TP, 1'b0, 1'b0, 1'b0, O_SET);
        add(1'b1, 1'b0, 1'b0, 1'b0, O_OFF);
`ifdef PWR_SEQ_AUTO_RETRY_EN
        // Three automatic retries, the fourth timeout stays in FAULT.
        to_init();
        for (int r = 0; r < 4; r++) begin
            add_n(TI - 1, 1'b1, 1'b0, 1'b0, O_SET);
            add(1'b1, 1'b1, 1'b0, 1'b0, O_FTMO);
            if (r < 3) begin
                add_n(TS - 1, 1'b1, 1'b0, 1'b0, O_FTMO);
                to_init();
            end else begin
                add_n(2 * TS, 1'b1, 1'b0, 1'b0, O_FTMO);
                add(1'b1, 1'b0, 1'b0, 1'b0, O_OFF);
            end
        end
`endif

        foreach (vq[i])
            apply_check("table", i, vq[i].rn, vq[i].pu, vq[i].fl, vq[i].id, vq[i].exp);

        // Randomized run against the reference model.
        m_ph = M_IDLE; m_age = 0; m_low = 0; m_retries = 0;
        m_req = 1'b0; m_hs = 1'b0; m_hb = 1'b0; m_err = 2'b00;
        pu = 1'b0; fl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rn = (i == 0) ? 1'b0 : ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 29) == 0) pu = ~pu;
            if (fl) fl = ($urandom_range(0, 2) != 0);
            else    fl = ($urandom_range(0, 149) == 0);
            id = ($urandom_range(0, 15) == 0);
            model_step(rn, pu, fl, id);
            apply_check("random", i, rn, pu, fl, id, model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pwr_up_seq.md
Name: pwr_up_seq

Overview:
- Power-up / enable sequencer for the segway controller.
- Consumes the synchronized reset `rst_n` from the reset synchronizer and the rider power request.
- Releases subsystem enables in a fixed order: sensors, then IMU init handshake, then balance loop, then motor drive.
- Performs ordered shutdown and latches faults (external fault or IMU init timeout) into a safe all-off state.

Parameters:
- CNT_W, 16, width of the shared state-duration counter.
- SETTLE_CYC, 16'd1000, cycles sensors are powered before `init_req` (1 .. 2**CNT_W-1).
- INIT_TMO, 16'd50000, max cycles in INIT waiting for `init_done` before fault.
- CAL_CYC, 16'd4000, cycles balance loop runs with motors off (integrator settle).
- STOP_CYC, 16'd500, cycles `bal_en` stays on after `mtr_en` drops during shutdown.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, driven by the reset synchronizer output.
- pwr_up  input  1  rider power request (level, already synchronized).
- fault  input  1  external fault (overcurrent / low battery), level.
- init_done  input  1  IMU init complete, level or pulse.
- init_req  output  1  one-cycle IMU init request pulse.
- sens_en  output  1  sensor/IMU power enable.
- bal_en  output  1  balance controller enable.
- mtr_en  output  1  motor drive enable.
- ready  output  1  sequence complete, running.
- fault_latched  output  1  sequencer is in FAULT.
- err_code  output  2  00 none, 01 external fault, 10 init timeout; held until FAULT exit.

Behaviour:
- All outputs registered. `rst_n` low at a clk edge: state IDLE, counter 0, all outputs 0, err_code 00.
- A single counter clears on every state transition and increments each cycle in a timed state.
- "Lasts N cycles" means exactly N clocks in the state.
- IDLE: all enables 0.
  - pwr_up=1 and fault=0 -> SETTLE.
  - fault in IDLE is not latched; it only blocks leaving IDLE.
- SETTLE: sens_en=1; after SETTLE_CYC cycles -> INIT.
- INIT: sens_en=1; init_req=1 on the first INIT cycle only.
  - init_done=1 on any INIT cycle, including the first -> CAL.
  - INIT_TMO cycles without init_done -> FAULT, err_code=10.
  - init_done and timeout in the same cycle: init_done wins.
- CAL: sens_en=1, bal_en=1, mtr_en=0; after CAL_CYC cycles -> RUN.
- RUN: sens_en=1, bal_en=1, mtr_en=1, ready=1; stays until pwr_up drop or fault.
- SHUTDN: entered when pwr_up=0 in SETTLE/INIT/CAL/RUN.
  - mtr_en=0 and ready=0 from the first SHUTDN cycle.
  - bal_en and sens_en keep their pre-shutdown values for STOP_CYC cycles, then -> IDLE with all 0.
  - pwr_up reasserting during SHUTDN does not abort it; IDLE then re-evaluates.
- FAULT: entered from any state except IDLE when fault=1, also from SHUTDN.
  - All enables and ready are 0 on the first FAULT cycle.
  - fault_latched=1; err_code=01 (or 10 on timeout).
- Priority per cycle: fault > pwr_up drop > timer/handshake progress.
- FAULT exit without the optional feature: requires pwr_up=0 and fault=0 on the same cycle -> IDLE; fault_latched and err_code clear on entry to IDLE.
- Reset mid-sequence (any state): next state IDLE, all outputs 0; no shutdown ordering is applied, since reset supersedes it.
- Counter never wraps; timed states leave at the terminal count.

Optional Feature:
- Macro: PWR_SEQ_AUTO_RETRY_EN.
- Defined: FAULT with err_code=10 (init timeout only) auto-retries.
  - After fault is low for SETTLE_CYC cycles -> SETTLE, with err_code cleared.
  - Max 3 retries, counted by a 2-bit retry counter cleared on reaching RUN or on reset.
  - The 4th timeout stays in FAULT, with exit per the normal rule.
- Undefined: no retry logic or counter; FAULT exit only via the pwr_up=0 / fault=0 rule.

Decomposition:
- Package pwr_seq_pkg holds:
  - the state enum (IDLE, SETTLE, INIT, CAL, RUN, SHUTDN, FAULT);
  - the err_code enum (ERR_NONE, ERR_EXT, ERR_TMO);
  - MAX_RETRY=2'd3.
- One sub-module, seq_timer: CNT_W counter with synchronous clear and a compare-to-terminal `done` output. It is instantiated once and shared by all timed states.

Test Plan (SETTLE_CYC=4, INIT_TMO=20, CAL_CYC=8, STOP_CYC=3):
- Nominal: reset, then pwr_up=1.
  - sens_en rises 1 cycle later; init_req pulses exactly once, 4 cycles after that.
  - init_done pulses 5 cycles later -> bal_en=1; 8 cycles later mtr_en=1 and ready=1.
- Shutdown: pwr_up=0 in RUN -> next cycle mtr_en=0, ready=0; bal_en stays high 3 cycles, then all outputs 0 and state IDLE.
- Init timeout: no init_done.
  - 20 cycles after init_req: fault_latched=1, err_code=10, sens_en=0.
  - pwr_up=0 -> IDLE, err_code=00.
- Fault in CAL: fault=1 -> next cycle bal_en=0, sens_en=0, err_code=01. Exit only once pwr_up=0 and fault=0.
- Priority/boundary:
  - fault and pwr_up drop in the same RUN cycle -> FAULT, not SHUTDN.
  - init_done on the timeout cycle -> CAL.
  - fault=1 in IDLE with pwr_up=1 -> stays IDLE, fault_latched=0.
- Reset mid-RUN: rst_n=0 for 1 cycle -> all outputs 0 next edge.
- With PWR_SEQ_AUTO_RETRY_EN: three retries observed on timeout, then the fourth timeout remains in FAULT.
